// File: rtl/learner_sched_pkg.sv
// learner_pkg: slot learner state encoding and its one-step transition function.
package learner_pkg;

  // guess = state[1]; P1/P0 are the one-grant confirmation states before a flip
  typedef enum logic [1:0] {
    S0 = 2'b00,
    P1 = 2'b01,
    S1 = 2'b11,
    P0 = 2'b10
  } lstate_t;

  function automatic lstate_t next_lstate(lstate_t s, bit result);
    case (s)
      S0:      next_lstate = result ? P1 : S0;
      P1:      next_lstate = S1;
      S1:      next_lstate = result ? S1 : P0;
      default: next_lstate = S0;
    endcase
  endfunction

endpackage

// File: rtl/learner_sched_if.sv
// learner_sched_if: request/result inputs and grant/response outputs of learner_sched.
interface learner_sched_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            clr;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] result;
  logic [NREQ-1:0] grant;
  logic            rsp_vld;
  logic [IW-1:0]   rsp_id;
  logic            guess;
  logic            miss;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output clr, req, result,
    input  grant, rsp_vld, rsp_id, guess, miss, miss_cnt
  );

  modport slave (
    input  clr, req, result,
    output grant, rsp_vld, rsp_id, guess, miss, miss_cnt
  );
endinterface

// File: rtl/learner_sched_rr_arb.sv
// rr_arb: combinational round-robin pick, searching upward from i_ptr+1 with wrap.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_vld && i_req[IW'((int'(i_ptr) + k) % NREQ)]) begin
        o_vld = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
      end
    end
  end

  assign o_gnt = o_vld ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/learner_sched.sv
// learner_sched: round-robin shared slow-learner predictor with per-slot state.
// Optional miss counter built only when LEARNER_SCHED_MISS_CNT_EN is defined.
module learner_sched
  import learner_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  learner_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  lstate_t         r_state     [NREQ];
  lstate_t         w_state_nxt [NREQ];
  logic [NREQ-1:0] r_grant, w_gnt, w_req_m;
  logic [IW-1:0]   r_gidx, r_ptr, w_idx, w_ptr_eff;
  logic            r_first, w_vld, w_gvld, w_res, w_guess, w_miss;
  logic            r_rsp_vld, r_guess, r_miss;
  logic [IW-1:0]   r_rsp_id;

  assign w_gvld  = |r_grant;
  assign w_res   = bus.result[r_gidx];
  assign w_guess = r_state[r_gidx][1];
  assign w_miss  = w_guess ^ w_res;

  // The visible grant is already served: mask it and search past it, so a
  // held req is re-granted at most every other cycle. r_first starts at slot 0.
  assign w_req_m   = bus.req & ~r_grant;
  assign w_ptr_eff = r_first ? IW'(NREQ - 1) : (w_gvld ? r_gidx : r_ptr);

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req (w_req_m),
    .i_ptr (w_ptr_eff),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) w_state_nxt[i] = r_state[i];
    if (bus.clr) begin
      for (int i = 0; i < NREQ; i++) w_state_nxt[i] = S0;
    end else if (w_gvld) begin
      w_state_nxt[r_gidx] = next_lstate(r_state[r_gidx], w_res);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_state[i] <= S0;
    end else begin
      for (int i = 0; i < NREQ; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_first   <= 1'b1;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_guess   <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      if (w_gvld) r_ptr <= r_gidx;
      if (bus.clr) begin
        r_grant   <= '0;
        r_rsp_vld <= 1'b0;
        r_miss    <= 1'b0;
      end else begin
        r_grant   <= w_gnt;
        r_gidx    <= w_idx;
        if (w_vld) r_first <= 1'b0;
        r_rsp_vld <= w_gvld;
        r_miss    <= w_gvld & w_miss;
        if (w_gvld) begin
          r_rsp_id <= r_gidx;
          r_guess  <= w_guess;
        end
      end
    end
  end

`ifdef LEARNER_SCHED_MISS_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_cnt <= '0;
    else if (bus.clr)                                r_cnt <= '0;
    else if (w_gvld && w_miss && (r_cnt != '1))      r_cnt <= r_cnt + 1'b1;
  end

  assign bus.miss_cnt = r_cnt;
`else
  assign bus.miss_cnt = {CNT_W{1'b0}};
`endif

  assign bus.grant   = r_grant;
  assign bus.rsp_vld = r_rsp_vld;
  assign bus.rsp_id  = r_rsp_id;
  assign bus.guess   = r_guess;
  assign bus.miss    = r_miss;

endmodule

// File: tb/tb_learner_sched.sv
// tb_learner_sched: randomized and directed checks of learner_sched against a guess/pending model.
module tb_learner_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  learner_sched_if #(.NREQ(4), .CNT_W(2)) bus ();

  learner_sched #(.NREQ(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // model: each learner is a guess bit plus a "disagreement seen" flag that
  // flips the guess on the next sample regardless of its value
  logic [3:0] mg, mp;
  int         m_last;
  logic [3:0] e_grant;
  logic       e_vld, e_guess, e_miss;
  logic [1:0] e_id, e_cnt;

  task automatic m_reset();
    mg = '0; mp = '0; m_last = -1;
    e_grant = '0; e_vld = 0; e_guess = 0; e_miss = 0; e_id = '0; e_cnt = '0;
  endtask

  task automatic m_step(input logic c, input logic [3:0] rq, input logic [3:0] rs);
    int id;
    logic [3:0] msk, ng;
    logic [1:0] jj;
    id = -1;
    for (int i = 0; i < 4; i++) if (e_grant[i]) id = i;
    if (id >= 0) m_last = id;
    if (c) begin
      mg = '0; mp = '0; e_cnt = '0; e_vld = 0; e_miss = 0; e_grant = '0;
    end else begin
      e_vld = (id >= 0);
      e_miss = 0;
      if (id >= 0) begin
        e_id    = 2'(id);
        e_guess = mg[id];
        e_miss  = mg[id] ^ rs[id];
        if (mp[id]) begin mg[id] = ~mg[id]; mp[id] = 0; end
        else if (rs[id] != mg[id]) mp[id] = 1;
`ifdef LEARNER_SCHED_MISS_CNT_EN
        if (e_miss && e_cnt != 2'd3) e_cnt = e_cnt + 2'd1;
`endif
      end
      msk = rq & ~e_grant;
      ng  = '0;
      for (int k = 0; k < 4; k++) begin
        jj = 2'(m_last + 1 + k);
        if (ng == '0 && msk[jj]) ng[jj] = 1'b1;
      end
      e_grant = ng;
    end
  endtask

  // advance model and DUT by one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    m_step(bus.clr, bus.req, bus.result);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.clr = 0; bus.req = '0; bus.result = '0;
    do_reset();
    checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    checks++; if (bus.rsp_vld !== 1'b0) begin failures++; $display("FAIL reset_rsp_vld: got %b want 0", bus.rsp_vld); end
    checks++; if (bus.rsp_id !== 2'd0 || bus.guess !== 1'b0 || bus.miss !== 1'b0) begin
      failures++; $display("FAIL reset_rsp: got id=%0d guess=%b miss=%b want 0/0/0", bus.rsp_id, bus.guess, bus.miss); end
    checks++; if (bus.miss_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", bus.miss_cnt); end
    step();
    checks++; if (bus.grant !== 4'b0 || bus.rsp_vld !== 1'b0) begin
      failures++; $display("FAIL idle: got grant=%b vld=%b want 0000/0", bus.grant, bus.rsp_vld); end
  endtask

  task automatic test_single_learn();
    logic [3:0] tg, tm;
    int n;
    tg = 4'b1100; tm = 4'b0011;   // response i at bit i: guesses 0,0,1,1; misses 1,1,0,0
    n = 0;
    bus.req = 4'b0001; bus.result = 4'b0001;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      checks++; if (bus.grant !== e_grant) begin failures++; $display("FAIL single_grant: got %b want %b", bus.grant, e_grant); end
      if (bus.rsp_vld) begin
        checks++; if (bus.guess !== tg[n] || bus.miss !== tm[n]) begin
          failures++; $display("FAIL single_rsp%0d: got guess=%b miss=%b want %b/%b", n, bus.guess, bus.miss, tg[n], tm[n]); end
        n++;
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL single_count: got %0d responses want 4", n); end
`ifdef LEARNER_SCHED_MISS_CNT_EN
    checks++; if (bus.miss_cnt !== 2'd2) begin failures++; $display("FAIL single_cnt: got %0d want 2", bus.miss_cnt); end
`else
    checks++; if (bus.miss_cnt !== 2'd0) begin failures++; $display("FAIL single_cnt: got %0d want 0", bus.miss_cnt); end
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset();
    bus.req = 4'b1111; bus.result = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bus.grant !== seq[c]) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", c, bus.grant, seq[c]); end
      if (c > 0) begin
        checks++; if (bus.rsp_vld !== 1'b1 || bus.rsp_id !== 2'(c - 1) || bus.guess !== 1'b0) begin
          failures++; $display("FAIL rr_rsp%0d: got vld=%b id=%0d guess=%b want 1/%0d/0", c, bus.rsp_vld, bus.rsp_id, bus.guess, c - 1); end
      end
    end
    bus.req = '0;
    step(); step();
  endtask

  task automatic test_slot2_unlearn();
    logic [2:0] tg;
    int n, ph;
    tg = 3'b011;   // after training: guesses 1,1,0
    n = 0; ph = 0;
    bus.clr = 1; step(); bus.clr = 0;
    bus.req = 4'b0100; bus.result = 4'b0100;
    for (int c = 0; c < 40 && n < 3; c++) begin
      step();
      if (bus.rsp_vld && bus.rsp_id == 2'd2) begin
        if (ph < 2) begin
          ph++;
          if (ph == 2) bus.result = 4'b0000;
        end else begin
          checks++; if (bus.guess !== tg[n] || bus.guess !== e_guess || bus.miss !== e_miss) begin
            failures++; $display("FAIL slot2_rsp%0d: got guess=%b miss=%b want %b/%b", n, bus.guess, bus.miss, tg[n], e_miss); end
          n++;
        end
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL slot2_count: got %0d want 3", n); end
    bus.req = '0; step(); step();
  endtask

  task automatic test_clr();
    int seen;
    bus.req = 4'b1111; bus.result = 4'b1111;
    repeat (10) step();
    for (int c = 0; c < 4 && bus.grant == 4'b0; c++) step();
    checks++; if (bus.grant === 4'b0) begin failures++; $display("FAIL clr_setup: got grant=%b want nonzero", bus.grant); end
    bus.clr = 1; step(); bus.clr = 0;
    checks++; if (bus.rsp_vld !== 1'b0 || bus.grant !== 4'b0) begin
      failures++; $display("FAIL clr_suppress: got vld=%b grant=%b want 0/0000", bus.rsp_vld, bus.grant); end
    checks++; if (bus.miss_cnt !== 2'd0) begin failures++; $display("FAIL clr_cnt: got %0d want 0", bus.miss_cnt); end
    bus.result = '0; seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.rsp_vld) begin
        seen++;
        checks++; if (bus.guess !== 1'b0) begin failures++; $display("FAIL clr_guess slot%0d: got %b want 0", bus.rsp_id, bus.guess); end
      end
    end
    checks++; if (seen < 8) begin failures++; $display("FAIL clr_poll: got %0d responses want >=8", seen); end
    bus.req = '0; step(); step();
  endtask

  task automatic test_saturate();
    bus.clr = 1; step(); bus.clr = 0;
    bus.req = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      bus.result = {3'b000, ~mg[0]};   // always disagree with the slot's current guess
      step();
      checks++; if (bus.miss_cnt !== e_cnt) begin failures++; $display("FAIL sat_cnt%0d: got %0d want %0d", c, bus.miss_cnt, e_cnt); end
    end
`ifdef LEARNER_SCHED_MISS_CNT_EN
    checks++; if (bus.miss_cnt !== 2'd3) begin failures++; $display("FAIL sat_hold: got %0d want 3", bus.miss_cnt); end
`else
    checks++; if (bus.miss_cnt !== 2'd0) begin failures++; $display("FAIL sat_hold: got %0d want 0", bus.miss_cnt); end
`endif
    bus.req = '0; step(); step();
  endtask

  task automatic test_rst_midstream();
    bus.req = 4'b1111; bus.result = 4'($urandom);
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.grant !== 4'b0 || bus.rsp_vld !== 1'b0) begin
      failures++; $display("FAIL rst_async: got grant=%b vld=%b want 0000/0", bus.grant, bus.rsp_vld); end
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = 4'b1010;
    step();
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL rst_first_grant: got %b want 0010", bus.grant); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req    = 4'($urandom);
      bus.result = 4'($urandom);
      bus.clr    = ($urandom_range(0, 31) == 0);
      step();
      checks++; if (bus.grant !== e_grant) begin failures++; $display("FAIL rnd_grant@%0d: got %b want %b", c, bus.grant, e_grant); end
      checks++; if (bus.rsp_vld !== e_vld) begin failures++; $display("FAIL rnd_vld@%0d: got %b want %b", c, bus.rsp_vld, e_vld); end
      if (e_vld) begin
        checks++; if (bus.rsp_id !== e_id || bus.guess !== e_guess || bus.miss !== e_miss) begin
          failures++; $display("FAIL rnd_rsp@%0d: got id=%0d guess=%b miss=%b want %0d/%b/%b",
                               c, bus.rsp_id, bus.guess, bus.miss, e_id, e_guess, e_miss); end
      end
      checks++; if (bus.miss_cnt !== e_cnt) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, bus.miss_cnt, e_cnt); end
    end
    bus.clr = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_learn();
    test_round_robin();
    test_slot2_unlearn();
    test_clr();
    test_saturate();
    test_rst_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
